// File: rtl/y_mux_pkg.sv
// y_mux_arb shared package: width helper, mode encodings, channel limits.
package y_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int CHANNELS_MIN = 2;
  localparam int CHANNELS_MAX = 16;

  // Minimum of 1 so a 2-channel build still gets a usable select field.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/y_mux_arb_if.sv
// y_mux_arb handshake bundle; out_parity exists only with Y_MUX_PARITY_EN.
interface y_mux_arb_if
  import y_mux_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4
) ();

  localparam int SEL_W = clog2(CHANNELS);

  logic [CHANNELS*SIZE-1:0] in_data;
  logic [CHANNELS-1:0]      in_valid;
  logic [CHANNELS-1:0]      in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [SIZE-1:0]          out_data;
  logic [SEL_W-1:0]         out_chan;
  logic                     out_valid;
  logic                     out_ready;
`ifdef Y_MUX_PARITY_EN
  logic                     out_parity;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid, out_parity
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid, out_parity
  );
`else
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
`endif

endinterface

// File: rtl/y_rr_pick.sv
// Rotating priority picker: first valid channel at or after start, modulo CHANNELS.
module y_rr_pick
  import y_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SEL_W-1:0]    start,
  output logic [SEL_W-1:0]    idx,
  output logic                found
);

  int j;

  // Walk from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (valid[j]) begin
        idx   = SEL_W'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/y_mux_arb.sv
// Registered N-channel mux with fixed or round-robin grant.
// Optional out_parity with Y_MUX_PARITY_EN.
module y_mux_arb
  import y_mux_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4
) (
  input logic        clk,
  input logic        reset,
  y_mux_arb_if.slave bus
);

  localparam int SEL_W = clog2(CHANNELS);
  localparam int PAD_N = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_ok;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             load;
  logic             take;
  logic [PAD_N-1:0] valid_pad;
  logic [SIZE-1:0]  pick_data;
  logic [SIZE-1:0]  data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;

  y_rr_pick #(
    .CHANNELS(CHANNELS)
  ) u_pick (
    .valid(bus.in_valid),
    .start(ptr),
    .idx  (rr_idx),
    .found(rr_ok)
  );

  // Zero padding makes an out-of-range sel read as "not valid".
  assign valid_pad = PAD_N'(bus.in_valid);

  always_comb begin
    grant    = bus.sel;
    grant_ok = valid_pad[bus.sel];
    if (bus.mode == MODE_RR) begin
      grant    = rr_idx;
      grant_ok = rr_ok;
    end
  end

  assign load = !valid_q || bus.out_ready;
  assign take = !reset && load && grant_ok;

  always_comb begin
    bus.in_ready = '0;
    pick_data    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        bus.in_ready[i] = take;
        pick_data       = bus.in_data[i*SIZE +: SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (take) begin
      data_q  <= pick_data;
      chan_q  <= grant;
      valid_q <= 1'b1;
      if (bus.mode == MODE_RR) begin
        ptr <= (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
      end
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

`ifdef Y_MUX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (take) begin
      parity_q <= ^pick_data;
    end
  end

  assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_y_mux_arb.sv
// Scoreboard bench for y_mux_arb, CHANNELS=5, SIZE=32.
// Directed steps plus a mixed-mode random phase.
module tb_y_mux_arb;
  import y_mux_pkg::*;

  localparam int SIZE = 32;
  localparam int CH   = 5;
  localparam int SW   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  y_mux_arb_if #(.SIZE(SIZE), .CHANNELS(CH)) bus ();

  y_mux_arb #(
    .SIZE    (SIZE),
    .CHANNELS(CH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [SIZE-1:0] d;
    logic [SW-1:0]   c;
  } exp_t;

  exp_t          q[$];
  int            nvec = 0;
  int            nerr = 0;
  logic          m_ov;
  logic [SW-1:0] m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [SIZE-1:0] v);
    bus.in_data[c*SIZE +: SIZE] = v;
  endtask

  task automatic fill(input int n);
    for (int c = 0; c < CH; c++) set_ch(c, {8'hA0 + 8'(c), 24'(n)});
  endtask

  // Reference step: predict readies, check the held word, then advance one clock.
  task automatic cyc();
    logic          ok;
    logic          ld;
    logic [SW-1:0] g;
    logic [CH-1:0] er;
    exp_t          e;
    #1;
    ok = 1'b0;
    g  = '0;
    if (bus.mode == MODE_FIXED) begin
      g = bus.sel;
      if (int'(bus.sel) < CH) ok = bus.in_valid[bus.sel];
    end else begin
      for (int k = 0; k < CH; k++) begin
        int j;
        j = (int'(m_ptr) + k) % CH;
        if (!ok && bus.in_valid[j]) begin
          ok = 1'b1;
          g  = SW'(j);
        end
      end
    end
    ld = !m_ov || bus.out_ready;
    er = (ld && ok) ? (CH'(1) << g) : '0;
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (m_ov && q.size() > 0) begin
      e = q[0];
      chk("out_data", 64'(bus.out_data), 64'(e.d));
      chk("out_chan", 64'(bus.out_chan), 64'(e.c));
`ifdef Y_MUX_PARITY_EN
      chk("out_parity", 64'(bus.out_parity), 64'(^e.d));
`endif
      if (bus.out_ready) void'(q.pop_front());
    end
    if (ld && ok) begin
      e.d = bus.in_data[int'(g)*SIZE +: SIZE];
      e.c = g;
      q.push_back(e);
      m_ov = 1'b1;
      if (bus.mode == MODE_RR) m_ptr = (int'(g) == CH - 1) ? '0 : SW'(int'(g) + 1);
    end else if (bus.out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ov  = 1'b0;
    m_ptr = '0;
    q.delete();
  endtask

  initial begin
    bus.in_valid  = '1;
    bus.mode      = MODE_RR;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    fill(0);
    model_reset();

    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_chan", 64'(bus.out_chan), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
`ifdef Y_MUX_PARITY_EN
    chk("rst_parity", 64'(bus.out_parity), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Round-robin fairness with all channels valid
    for (int k = 0; k < 10; k++) begin
      fill(k + 1);
      #1;
      chk("rr_seq", 64'(bus.in_ready), 64'(CH'(1) << (k % CH)));
      cyc();
    end

    // Fixed select
    bus.mode = MODE_FIXED;
    bus.sel  = 3'd2;
    fill(20);
    set_ch(2, 32'hDEADBEEF);
    #1;
    chk("fix_ready", 64'(bus.in_ready), 64'(5'b00100));
    cyc();
    chk("fix_data", 64'(bus.out_data), 64'h0000_0000_DEAD_BEEF);
    chk("fix_chan", 64'(bus.out_chan), 64'd2);

    // Out-of-range select
    bus.sel = 3'd5;
    #1;
    chk("sel5_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    cyc();
    chk("sel5_drained", 64'(bus.out_valid), 64'd0);

    // Backpressure: held word, then release; ptr must not have moved
    bus.mode = MODE_RR;
    fill(30);
    cyc();
    bus.out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      fill(31 + r);
      cyc();
    end
    chk("bp_chan", 64'(bus.out_chan), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", 64'(bus.in_ready), 64'(5'b00010));
    cyc();

    // Sparse valids
    bus.in_valid = 5'b00001;
    cyc();
    bus.in_valid = 5'b01001;
    #1;
    chk("sparse_a", 64'(bus.in_ready), 64'(5'b01000));
    cyc();
    #1;
    chk("sparse_b", 64'(bus.in_ready), 64'(5'b00001));
    cyc();
    #1;
    chk("sparse_c", 64'(bus.in_ready), 64'(5'b01000));
    cyc();

    // Asynchronous reset mid-operation
    bus.in_valid = '1;
    cyc();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_data", 64'(bus.out_data), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_first", 64'(bus.in_ready), 64'(5'b00001));
    cyc();

`ifdef Y_MUX_PARITY_EN
    bus.mode = MODE_FIXED;
    bus.sel  = 3'd0;
    set_ch(0, 32'h0000_0007);
    cyc();
    chk("par7", 64'(bus.out_parity), 64'd1);
    set_ch(0, 32'h0000_0003);
    cyc();
    chk("par3", 64'(bus.out_parity), 64'd0);
`endif

    // Mixed-mode random phase
    for (int n = 0; n < 500; n++) begin
      bus.in_valid  = CH'($urandom);
      bus.mode      = 1'($urandom);
      bus.sel       = SW'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      for (int c = 0; c < CH; c++) set_ch(c, $urandom);
      cyc();
    end

    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/y_mux_arb.md
# y_mux_arb

Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output. Selection is either fixed, by a software-style select input, or round-robin arbitrated across valid channels. It generalises the combinational 4-to-1, SIZE-wide mux into a pipelined merge stage for datapaths that funnel several producers into one consumer.

## Interface
- SIZE, 32, data width per channel
- CHANNELS, 4, number of input channels (2..16, need not be a power of two)
- SEL_W, derived = clog2(CHANNELS) (min 1), width of select/channel-id fields; not overridable
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  CHANNELS*SIZE  channel i occupies bits [i*SIZE +: SIZE]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel chosen in fixed mode
- out_data  output  SIZE  registered selected data
- out_chan  output  SEL_W  registered index of the channel that produced out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word
- out_parity  output  1  only with Y_MUX_PARITY_EN: even parity of out_data

## Operation
- Output stage: a single register. `load = !out_valid || out_ready`.
- Grant, combinational each cycle:
  - Fixed mode (mode=0): grant = sel when in_valid[sel]; sel >= CHANNELS → no grant.
  - Round-robin mode (mode=1): grant = the first i with in_valid[i], searching ptr, ptr+1, … modulo CHANNELS.
- in_ready[i] = load && grant valid && grant==i. All other readies are 0, so at most one ready is high.
- Transfer on channel g when in_valid[g] && in_ready[g]:
  - out_data ← in_data[g], out_chan ← g, out_valid ← 1.
  - In round-robin mode, ptr ← (g+1 == CHANNELS) ? 0 : g+1.
- No transfer and out_ready=1: out_valid ← 0. out_data/out_chan hold their last values.
- ptr updates only on a round-robin transfer. Fixed-mode transfers leave ptr untouched.
- mode/sel changes take effect in the same cycle's grant. The word already held is unaffected.
- Producers must hold in_data/in_valid stable until accepted. The block tolerates violation, but such data is simply not captured.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0, out_parity=0. in_ready is 0 during reset.
- Reset mid-operation discards the held word immediately (asynchronous). No partial handshake survives.
- Latency: input acceptance in cycle n → out_valid at cycle n+1.
- Throughput: one word per cycle while out_ready=1 (simultaneous drain and load in the same edge).
- Backpressure: out_valid=1, out_ready=0 → all in_ready=0, and the output register and ptr hold.
- Wrap-around: ptr=CHANNELS-1 with a grant there → ptr=0. Non-power-of-two CHANNELS never produces ptr ≥ CHANNELS.
- All inputs valid in round-robin mode → grants cycle 0,1,…,CHANNELS-1,0 with no repeats.

## Configuration
- Y_MUX_PARITY_EN defined:
  - out_parity port exists, registered alongside out_data.
  - out_parity = ^in_data[g] at load, so that ^{out_data,out_parity}=0.
  - Follows the reset rules above.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package y_mux_pkg:
  - clog2 function.
  - Mode constants: MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Limits: CHANNELS_MIN=2, CHANNELS_MAX=16.
- Sub-module y_rr_pick: combinational rotating priority picker. Inputs are a valid vector and a start pointer; outputs are a grant index and grant-valid. It is instantiated once, and fixed mode bypasses it.
- Top: grant mux, ready decode, output register, ptr register.

## Test plan
- Reset: assert reset with all in_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0; release → first round-robin grant is channel 0.
- Fixed mode: SIZE=32, CHANNELS=4, mode=0, sel=2, in_data[2]=32'hDEADBEEF, all valid, out_ready=1 → in_ready=4'b0100, next cycle out_data=32'hDEADBEEF, out_chan=2. Then sel=3'd5 with CHANNELS=5 → no grant.
- Round-robin fairness: CHANNELS=5, mode=1, all valid, out_ready=1 for 10 cycles → out_chan sequence 0,1,2,3,4,0,1,2,3,4 with one word per cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles → in_ready=0, and out_data, out_chan and ptr are unchanged; the word is released on the first out_ready=1.
- Sparse valids: in_valid=4'b1001 and ptr=1 → grant 3, then ptr=0 → grant 0, then grant 3.
- Parity (Y_MUX_PARITY_EN): out_data=32'h00000007 → out_parity=1; out_data=32'h00000003 → out_parity=0. Also re-randomise 500 mixed-mode cycles against a reference model, comparing out_data, out_chan and the accepted-word order.
